// File: rtl/mult8_arbiter.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier among N
// requesters, with a GUARD cycle masking stale done and a saturating watchdog.
module mult8_arbiter #(
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] req_a,
  input  logic [8*N-1:0] req_b,
  output logic [N-1:0]   gnt,
  output logic [N-1:0]   resp_valid,
  output logic [7:0]     resp_product,
  output logic           resp_err,
  output logic           busy,
  output logic           mult_start,
  output logic [7:0]     mult_a,
  output logic [7:0]     mult_b,
  input  logic [7:0]     mult_product,
  input  logic           mult_done
);
  localparam int IW = $clog2(N);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_RST = IW'(N - 1);
  localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_GUARD,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] last_q, last_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    prod_q, prod_d;
  logic          err_q, err_d;
  logic [WW-1:0] wd_q, wd_d;

  logic [7:0]    op_a [N];
  logic [7:0]    op_b [N];
  logic          pick_found;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] cand;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      op_a[i] = req_a[8*i +: 8];
      op_b[i] = req_b[8*i +: 8];
    end
  end

  // Upward search starting one past the previous winner, wrapping modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    err_d   = err_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          last_d  = pick_idx;
          a_d     = op_a[pick_idx];
          b_d     = op_b[pick_idx];
          state_d = S_START;
        end
      end
      S_START: state_d = S_GUARD;
      S_GUARD: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout landing on the same edge
        if (mult_done) begin
          prod_d  = mult_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          if (wd_q != WD_LIMIT) wd_d = wd_q + 1'b1;
          if (wd_q >= WD_LIMIT - 1'b1) begin
            prod_d  = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= LAST_RST;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    gnt        = '0;
    resp_valid = '0;
    if (state_q == S_START) gnt[last_q] = 1'b1;
    if (state_q == S_RESP)  resp_valid[last_q] = 1'b1;
  end

  assign busy         = (state_q != S_IDLE);
  assign mult_start   = (state_q == S_START);
  assign mult_a       = a_q;
  assign mult_b       = b_q;
  assign resp_product = prod_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_mult8_arbiter.sv
// Self-checking bench for mult8_arbiter: behavioural multiplier model plus a
// round-robin / latency reference, directed and randomized operations.
module tb_mult8_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 64;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_a, req_b;
  logic [N-1:0]   gnt, resp_valid;
  logic [7:0]     resp_product;
  logic           resp_err, busy, mult_start;
  logic [7:0]     mult_a, mult_b;
  logic [7:0]     mult_product;
  logic           mult_done;

  logic [7:0] A [N];
  logic [7:0] B [N];

  int checks   = 0;
  int failures = 0;
  int ref_last = N - 1;

  int lat        = 8;
  bit never_done = 1'b0;
  bit stale      = 1'b0;

  mult8_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_a        (req_a),
    .req_b        (req_b),
    .gnt          (gnt),
    .resp_valid   (resp_valid),
    .resp_product (resp_product),
    .resp_err     (resp_err),
    .busy         (busy),
    .mult_start   (mult_start),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .mult_product (mult_product),
    .mult_done    (mult_done)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = A[i];
      req_b[8*i +: 8] = B[i];
    end
  end

  // Multiplier model: done rises `lat` edges after the start edge; in stale
  // mode the previous done/product linger for one extra cycle after start.
  int       m_cnt = 0;
  bit       m_clr = 1'b0;
  int       m_a = 0, m_b = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_done    <= 1'b0;
      mult_product <= 8'd0;
      m_cnt        <= 0;
      m_clr        <= 1'b0;
    end else if (mult_start) begin
      m_cnt <= lat;
      m_a   <= int'(mult_a);
      m_b   <= int'(mult_b);
      if (stale) m_clr <= 1'b1;
      else       mult_done <= 1'b0;
    end else begin
      if (m_clr) begin
        mult_done <= 1'b0;
        m_clr     <= 1'b0;
      end
      if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !never_done) begin
          mult_done    <= 1'b1;
          mult_product <= 8'((m_a * m_b) % 256);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_gnt"},        32'(gnt),          0);
    chk({pfx, "_resp_valid"}, 32'(resp_valid),   0);
    chk({pfx, "_resp_prod"},  32'(resp_product), 0);
    chk({pfx, "_resp_err"},   32'(resp_err),     0);
    chk({pfx, "_busy"},       32'(busy),         0);
    chk({pfx, "_mult_start"}, 32'(mult_start),   0);
    chk({pfx, "_mult_a"},     32'(mult_a),       0);
    chk({pfx, "_mult_b"},     32'(mult_b),       0);
  endtask

  function automatic int rr_pick(input int lastw, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++)
      if (m[(lastw + k) % N]) return (lastw + k) % N;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ref_last = N - 1;
  endtask

  // One arbitration round, checked against the reference; adjusts req at the
  // response cycle so the next IDLE sampling sees the new request set.
  task automatic do_op(input string tag, input bit drop_win, input logic [N-1:0] clr_m,
                       input logic [N-1:0] set_m, input bit new_ops, output int w);
    int  n;
    int  exp_w, exp_lat, exp_prod;
    bit  exp_err;
    bit  extra;
    n = 0;
    while (gnt == '0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_gnt_seen"}, 32'(n < 30), 1);
    exp_w = rr_pick(ref_last, req);
    w = exp_w;
    chk({tag, "_gnt"},     32'(gnt), 32'(1) << exp_w);
    chk({tag, "_start"},   32'(mult_start), 1);
    chk({tag, "_busy"},    32'(busy), 1);
    chk({tag, "_mult_a"},  32'(mult_a), 32'(A[exp_w]));
    chk({tag, "_mult_b"},  32'(mult_b), 32'(B[exp_w]));
    ref_last = exp_w;
    exp_err  = never_done || (lat > TIMEOUT);
    exp_lat  = exp_err ? 2 + TIMEOUT : 2 + lat;
    exp_prod = exp_err ? 0 : (int'(A[exp_w]) * int'(B[exp_w])) % 256;
    n = 0;
    extra = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (gnt != '0 || mult_start) extra = 1'b1;
    end while (resp_valid == '0 && n < TIMEOUT + 20);
    chk({tag, "_no_regrant"}, 32'(extra), 0);
    chk({tag, "_latency"},    32'(n), 32'(exp_lat));
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(1) << exp_w);
    chk({tag, "_product"},    32'(resp_product), 32'(exp_prod));
    chk({tag, "_err"},        32'(resp_err), 32'(exp_err));
    if (drop_win) req[exp_w] = 1'b0;
    req = (req & ~clr_m) | set_m;
    if (new_ops) begin
      A[exp_w] = 8'($urandom);
      B[exp_w] = 8'($urandom);
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, {30'd0, busy, resp_valid != '0}, 0);
  endtask

  initial begin
    int w;
    int order [5] = '{0, 1, 2, 3, 0};
    bit seen;
    for (int i = 0; i < N; i++) begin
      A[i] = 8'd0;
      B[i] = 8'd0;
    end
    #1;
    chk_zero("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single request
    A[0] = 8'd21; B[0] = 8'd18; lat = 8;
    req = 4'b0001;
    do_op("single", 1'b1, '0, '0, 1'b0, w);
    chk("single_winner", 32'(w), 0);

    // round robin with all requesters held high
    do_reset();
    A[0] = 8'd21; B[0] = 8'd18;
    A[1] = 8'd12; B[1] = 8'd11;
    A[2] = 8'd28; B[2] = 8'd56;
    A[3] = 8'd3;  B[3] = 8'd5;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      do_op("rr", 1'b0, (i == 4) ? 4'b1111 : 4'b0000, '0, 1'b0, w);
      chk("rr_order", 32'(w), 32'(order[i]));
    end

    // stale done lingering into GUARD must not be captured
    do_reset();
    stale = 1'b1;
    req = 4'b0011;
    do_op("stale1", 1'b1, '0, '0, 1'b0, w);
    do_op("stale2", 1'b1, '0, '0, 1'b0, w);
    chk("stale2_prod", 32'(resp_product), 132);
    stale = 1'b0;

    // watchdog abort then normal service
    never_done = 1'b1;
    req = 4'b0100;
    do_op("timeout", 1'b1, '0, '0, 1'b0, w);
    never_done = 1'b0;
    lat = 8;
    req = 4'b1000;
    do_op("after_to", 1'b1, '0, '0, 1'b0, w);

    // done on exactly the last watchdog tick, then one tick late
    lat = TIMEOUT;
    req = 4'b0001;
    do_op("done_last", 1'b1, '0, '0, 1'b0, w);
    lat = TIMEOUT + 1;
    req = 4'b0001;
    do_op("done_late", 1'b1, '0, '0, 1'b0, w);

    // randomized traffic
    for (int i = 0; i < N; i++) begin
      A[i] = 8'($urandom);
      B[i] = 8'($urandom);
    end
    for (int it = 0; it < 30; it++) begin
      lat = $urandom_range(1, 12);
      stale = 1'($urandom_range(0, 1));
      if (req == '0) req = 4'($urandom_range(1, 15));
      do_op("rand", 1'($urandom_range(0, 1)), '0, 4'($urandom_range(0, 15)), 1'b1, w);
    end
    req = '0;
    stale = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset in the middle of WAIT
    never_done = 1'b1;
    A[1] = 8'd7; B[1] = 8'd9;
    req = 4'b0010;
    begin
      int n;
      n = 0;
      while (gnt == '0 && n < 30) begin
        @(negedge clk);
        n++;
      end
      chk("midrst_gnt_seen", 32'(n < 30), 1);
    end
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    never_done = 1'b0;
    lat = 5;
    A[0] = 8'd200; B[0] = 8'd3;
    req = 4'b1111;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid != '0 || gnt != '0) seen = 1'b1;
    end
    chk("midrst_quiet", 32'(seen), 0);
    rst_n = 1'b1;
    ref_last = N - 1;
    do_op("post_rst", 1'b0, 4'b1111, '0, 1'b0, w);
    chk("post_rst_winner", 32'(w), 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
